// File: rtl/flappy_pkg.sv
// Shared game types and logo geometry for the flappy front end.
package flappy_pkg;

  // Game state encoding, consumed directly by the renderers.
  typedef enum logic [1:0] {
    TITLE = 2'd0,
    PLAY  = 2'd1,
    DYING = 2'd2,
    OVER  = 2'd3
  } game_state_t;

  // Logo placement in 4-pixel units.
  localparam int unsigned LOGO_ROW_FIRST = 10;
  localparam int unsigned LOGO_ROW_LAST  = 34;
  localparam int unsigned LOGO_COL_FIRST = 36;
  localparam int unsigned LOGO_COL_LAST  = 125;

  localparam int unsigned FRAME_CNT_W = 10;

  // Saturating increment for the frame counter; never wraps past all-ones.
  function automatic logic [FRAME_CNT_W-1:0] sat_inc(input logic [FRAME_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchronizer plus registered rising-edge pulse for the flap button.
// A pulse appears 3 clk after the raw edge. After reset the button must be seen
// low once before any press is accepted, so a button held through reset is ignored.
module btn_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  logic       sync1_q, sync2_q, prev_q, press_q, armed_q;
  logic [1:0] vld_q;

  // Synchronizer chain, edge detector and arming logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      press_q <= 1'b0;
      armed_q <= 1'b0;
      vld_q   <= 2'b00;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      vld_q   <= {vld_q[0], 1'b1};
      // sync2_q only reflects the real button once two edges have passed.
      armed_q <= armed_q | (vld_q[1] & ~sync2_q);
      press_q <= sync2_q & ~prev_q & armed_q;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/flap_ctrl.sv
// Flappy game-state controller: TITLE/PLAY/DYING/OVER FSM, flap pulse,
// game reset pulse, freeze flag and title-logo bob.
// Optional build macro FLAP_ATTRACT_EN: OVER returns to TITLE after
// ATTRACT_FRAMES frames without a press.
module flap_ctrl
  import flappy_pkg::*;
#(
  parameter int unsigned DIE_FRAMES     = 30,
  parameter int unsigned LOCK_FRAMES    = 20,
  parameter int unsigned BOB_AMP        = 4,
  parameter int unsigned BOB_DIV        = 4,
  parameter int unsigned ATTRACT_FRAMES = 600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       btn,
  input  logic       collision,
  output logic [1:0] state,
  output logic       flap,
  output logic       game_rst,
  output logic       freeze,
  output logic [3:0] logo_dy
);

  localparam logic [FRAME_CNT_W-1:0] DieCnt     = FRAME_CNT_W'(DIE_FRAMES);
  localparam logic [FRAME_CNT_W-1:0] LockCnt    = FRAME_CNT_W'(LOCK_FRAMES);
  localparam logic [3:0]             BobAmp     = 4'(BOB_AMP);
  localparam logic [3:0]             BobDivLast = 4'(BOB_DIV - 1);

  // Elaboration-time parameter range checks.
  if (BOB_AMP < 1 || BOB_AMP > 15) begin : g_bad_bob_amp
    $error("BOB_AMP out of range 1..15");
  end
  if (BOB_DIV < 1 || BOB_DIV > 15) begin : g_bad_bob_div
    $error("BOB_DIV out of range 1..15");
  end
  if (ATTRACT_FRAMES > 1023) begin : g_bad_attract
    $error("ATTRACT_FRAMES exceeds frame counter range");
  end

  logic                   press;
  game_state_t            state_q, state_d;
  logic [FRAME_CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic                   game_rst_q, game_rst_d;
  logic                   freeze_q, freeze_d;
  logic [3:0]             dy_q, dy_d, div_q, div_d;
  logic                   up_q, up_d;
  logic                   attract_hit;

  btn_sync u_btn_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (btn),
    .press (press)
  );

  assign cnt_inc = sat_inc(cnt_q);

`ifdef FLAP_ATTRACT_EN
  assign attract_hit = (cnt_q >= FRAME_CNT_W'(ATTRACT_FRAMES));
`else
  assign attract_hit = 1'b0;
`endif

  // Next-state and frame counter; the counter restarts from 0 on each state entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    unique case (state_q)
      TITLE: begin
        if (press) state_d = PLAY;
      end
      PLAY: begin
        if (collision) state_d = DYING;
      end
      DYING: begin
        cnt_d = cnt_q;
        if (frame_tick) begin
          if (cnt_inc == DieCnt) begin
            state_d = OVER;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      OVER: begin
        cnt_d = frame_tick ? cnt_inc : cnt_q;
        // A press and an attract timeout both land in TITLE.
        if ((press && cnt_q >= LockCnt) || attract_hit) begin
          state_d = TITLE;
          cnt_d   = '0;
        end
      end
      default: state_d = TITLE;
    endcase
  end

  // Registered outputs derived from the next state so they change with state.
  always_comb begin
    game_rst_d = (state_q == TITLE) && (state_d == PLAY);
    freeze_d   = (state_d == DYING) || (state_d == OVER);
  end

  // Logo bob: triangle wave while in TITLE, held at 0 with direction up elsewhere.
  always_comb begin
    dy_d  = dy_q;
    up_d  = up_q;
    div_d = div_q;
    if (state_q != TITLE || state_d != TITLE) begin
      dy_d  = '0;
      up_d  = 1'b1;
      div_d = '0;
    end else if (frame_tick) begin
      if (div_q == BobDivLast) begin
        div_d = '0;
        if (up_q) begin
          dy_d = dy_q + 4'd1;
          if (dy_q == BobAmp - 4'd1) up_d = 1'b0;
        end else begin
          dy_d = dy_q - 4'd1;
          if (dy_q == 4'd1) up_d = 1'b1;
        end
      end else begin
        div_d = div_q + 4'd1;
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= TITLE;
      cnt_q      <= '0;
      game_rst_q <= 1'b0;
      freeze_q   <= 1'b0;
      dy_q       <= '0;
      up_q       <= 1'b1;
      div_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      game_rst_q <= game_rst_d;
      freeze_q   <= freeze_d;
      dy_q       <= dy_d;
      up_q       <= up_d;
      div_q      <= div_d;
    end
  end

  // A press that coincides with a collision is swallowed.
  assign flap     = press && (state_q == PLAY) && !collision;
  assign state    = state_q;
  assign game_rst = game_rst_q;
  assign freeze   = freeze_q;
  assign logo_dy  = dy_q;

endmodule

// File: tb/tb_flap_ctrl.sv
// Directed bench for flap_ctrl: vector table for the game flow plus
// hand-written sequences for press latency, bob, collisions, reset and attract.
module tb_flap_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn = 1'b0;
  logic       collision = 1'b0;
  logic [1:0] state;
  logic       flap, game_rst, freeze;
  logic [3:0] logo_dy;

  int n_tests = 0;
  int n_fail  = 0;

  flap_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .btn        (btn),
    .collision  (collision),
    .state      (state),
    .flap       (flap),
    .game_rst   (game_rst),
    .freeze     (freeze),
    .logo_dy    (logo_dy)
  );

  always #5 clk = ~clk;

  localparam int ActColl  = 0;
  localparam int ActTicks = 1;
  localparam int ActPress = 2;

  typedef struct {
    string      name;
    int         act;
    int         arg;
    logic [1:0] st;
    logic       frz;
    logic [3:0] dy;
  } vec_t;

  vec_t vecs[10];
  int   bob_exp[10];

  task automatic chk(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      frame_tick = 1'b1;
      cyc(1);
      frame_tick = 1'b0;
      cyc(3);
    end
  endtask

  task automatic press_btn();
    btn = 1'b1;
    cyc(6);
    btn = 1'b0;
    cyc(4);
  endtask

  initial begin
    bob_exp = '{0, 1, 2, 3, 4, 3, 2, 1, 0, 1};
    vecs[0] = '{"die_entry",     ActColl,  0,  2'd2, 1'b1, 4'd0};
    vecs[1] = '{"dying_29",      ActTicks, 29, 2'd2, 1'b1, 4'd0};
    vecs[2] = '{"dying_30",      ActTicks, 1,  2'd3, 1'b1, 4'd0};
    vecs[3] = '{"over_10",       ActTicks, 10, 2'd3, 1'b1, 4'd0};
    vecs[4] = '{"over_coll",     ActColl,  0,  2'd3, 1'b1, 4'd0};
    vecs[5] = '{"over_lock_prs", ActPress, 0,  2'd3, 1'b1, 4'd0};
    vecs[6] = '{"over_20",       ActTicks, 10, 2'd3, 1'b1, 4'd0};
    vecs[7] = '{"over_exit_prs", ActPress, 0,  2'd0, 1'b0, 4'd0};
    vecs[8] = '{"title_coll",    ActColl,  0,  2'd0, 1'b0, 4'd0};
    vecs[9] = '{"title_prs",     ActPress, 0,  2'd1, 1'b0, 4'd0};

    // Reset values.
    #2;
    chk("rst_state", state, 0);
    chk("rst_flap", flap, 0);
    chk("rst_game_rst", game_rst, 0);
    chk("rst_freeze", freeze, 0);
    chk("rst_logo_dy", logo_dy, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(4);

    // Logo bob: one step per 4 ticks as a triangle wave.
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("bob_%0d", k), logo_dy, bob_exp[k]);
      tick(4);
    end

    // TITLE press: pulse 3 clk after the edge, PLAY and game_rst on the next edge.
    btn = 1'b1;
    cyc(3);
    chk("title_pre_state", state, 0);
    chk("title_pre_grst", game_rst, 0);
    cyc(1);
    chk("title_play", state, 1);
    chk("title_grst", game_rst, 1);
    chk("title_play_dy", logo_dy, 0);
    chk("title_flap", flap, 0);
    cyc(1);
    chk("grst_one_cycle", game_rst, 0);
    btn = 1'b0;
    cyc(4);

    // PLAY press: flap for exactly one cycle.
    btn = 1'b1;
    cyc(2);
    chk("flap_early", flap, 0);
    cyc(1);
    chk("flap_pulse", flap, 1);
    cyc(1);
    chk("flap_end", flap, 0);
    btn = 1'b0;
    cyc(4);

    // Vector table: die, lock, exit, new game.
    for (int i = 0; i < 10; i++) begin
      case (vecs[i].act)
        ActColl: begin
          collision = 1'b1;
          cyc(1);
          collision = 1'b0;
          cyc(1);
        end
        ActTicks: tick(vecs[i].arg);
        default:  press_btn();
      endcase
      chk({vecs[i].name, "_state"}, state, vecs[i].st);
      chk({vecs[i].name, "_freeze"}, freeze, vecs[i].frz);
      chk({vecs[i].name, "_dy"}, logo_dy, vecs[i].dy);
      chk({vecs[i].name, "_flap"}, flap, 0);
    end

    // Press and collision on the same PLAY cycle: DYING, no flap.
    btn = 1'b1;
    cyc(3);
    collision = 1'b1;
    #1;
    chk("simul_flap", flap, 0);
    cyc(1);
    collision = 1'b0;
    chk("simul_state", state, 2);
    chk("simul_freeze", freeze, 1);
    btn = 1'b0;
    cyc(3);

    // Asynchronous reset in DYING.
    tick(3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, 0);
    chk("arst_freeze", freeze, 0);
    chk("arst_flap", flap, 0);
    chk("arst_grst", game_rst, 0);
    chk("arst_dy", logo_dy, 0);

    // Button held through reset release must not start a game.
    btn = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(10);
    chk("held_rst_state", state, 0);
    btn = 1'b0;
    cyc(4);
    press_btn();
    chk("after_release_state", state, 1);

    // Attract timeout from OVER.
    collision = 1'b1;
    cyc(1);
    collision = 1'b0;
    tick(30);
    chk("attract_over", state, 3);
    tick(600);
    cyc(2);
`ifdef FLAP_ATTRACT_EN
    chk("attract_state", state, 0);
`else
    chk("attract_state", state, 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flap_ctrl.md
FLAP_CTRL -- requirements
Module: flap_ctrl

Interface
REQ-001 Parameter DIE_FRAMES, default 30: number of frame_tick pulses spent in DYING.
REQ-002 Parameter LOCK_FRAMES, default 20: number of frame_tick pulses in OVER during which presses are ignored.
REQ-003 Parameter BOB_AMP, default 4: peak logo bob offset in 4-pixel logo rows, range 1..15.
REQ-004 Parameter BOB_DIV, default 4: frame_tick pulses per bob step, range 1..15.
REQ-005 Parameter ATTRACT_FRAMES, default 600: OVER timeout in frames; used only when the attract feature is compiled in.
REQ-006 clk  in  1  pixel/system clock.
REQ-007 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-008 frame_tick  in  1  one-cycle pulse at the start of each vertical blank.
REQ-009 btn  in  1  raw asynchronous flap button, active-high.
REQ-010 collision  in  1  bird/pipe/ground hit, level, synchronous to clk.
REQ-011 state  out  2  game state: 0 TITLE, 1 PLAY, 2 DYING, 3 OVER; consumed directly by the logo and sprite renderers.
REQ-012 flap  out  1  one-cycle press pulse, valid in PLAY only.
REQ-013 game_rst  out  1  one-cycle pulse on every TITLE->PLAY transition; clears bird, pipes and score.
REQ-014 freeze  out  1  high in DYING and OVER; stops scrolling and pipe motion.
REQ-015 logo_dy  out  4  unsigned vertical logo offset in logo rows, 0..BOB_AMP.

Function
REQ-016 btn SHALL pass through a 2-flop synchronizer and a rising-edge detector; press is a single-cycle pulse 3 clk after a btn rising edge.
REQ-017 FSM transitions SHALL take effect on the clk edge following the qualifying condition; no transition waits for frame_tick unless stated.
REQ-018 TITLE: press -> PLAY; game_rst is asserted in the same cycle that state becomes PLAY.
REQ-019 PLAY: press SHALL produce flap in the same cycle; collision=1 -> DYING, with no flap emitted in that cycle.
REQ-020 PLAY: simultaneous press and collision -> DYING, with no flap.
REQ-021 DYING: frame counter cleared on entry, incremented per frame_tick; on the tick that makes the count equal DIE_FRAMES -> OVER; presses ignored.
REQ-022 OVER: frame counter cleared on entry; presses ignored while count < LOCK_FRAMES; press with count >= LOCK_FRAMES -> TITLE.
REQ-023 The frame counter SHALL be 10 bits and saturate at 1023, with no wrap.
REQ-024 Bob: in TITLE only, a divider counts frame_tick; every BOB_DIV ticks logo_dy steps ±1 as a triangle wave 0->BOB_AMP->0, reversing direction at both ends.
REQ-025 On entry to TITLE, logo_dy SHALL be 0 with the direction set to up and the divider at 0; outside TITLE, logo_dy holds 0.
REQ-026 freeze SHALL be a registered decode of state, changing in the same cycle as state.
REQ-027 collision SHALL be ignored in every state except PLAY.

Reset
REQ-028 While rst_n=0: state=TITLE, flap=0, game_rst=0, freeze=0, logo_dy=0, all counters 0, synchronizer flops 0.
REQ-029 Reset deasserted mid-press SHALL NOT generate a press unless btn is observed low and then high after release.

Configuration
REQ-030 Macro FLAP_ATTRACT_EN defined: in OVER, the frame count reaching ATTRACT_FRAMES with no press -> TITLE; a press has priority on the same cycle.
REQ-031 Macro FLAP_ATTRACT_EN undefined: OVER exits only by press, and the ATTRACT_FRAMES parameter is unused.

Structure
REQ-032 Package flappy_pkg SHALL hold the game_state_t enum (TITLE, PLAY, DYING, OVER, 2-bit) and the logo geometry constants (logo rows 10..34, columns 36..125, in 4-pixel units).
REQ-033 Sub-module btn_sync (2-flop synchronizer plus rising-edge pulse) SHALL be instantiated once; everything else is inline.

Verification
REQ-034 Reset, then btn high for 10 clk -> press 3 clk after the edge; state 0->1; game_rst pulses 1 cycle; logo_dy=0.
REQ-035 In PLAY, press -> flap=1 for exactly 1 cycle; collision=1 -> state=2 next cycle, freeze=1; 30 frame_ticks -> state=3.
REQ-036 In OVER, press at tick 10 -> still 3; press after tick 20 -> state=0.
REQ-037 In TITLE with 40 frame_ticks, BOB_AMP=4, BOB_DIV=4 -> logo_dy sequence 0,1,2,3,4,3,2,1,0,1, one step per 4 ticks.
REQ-038 collision and press in the same PLAY cycle -> state=2, flap=0; rst_n pulsed low during DYING -> all outputs at reset values asynchronously.
REQ-039 With FLAP_ATTRACT_EN defined, OVER with no press for 600 ticks -> state=0; with it undefined, state stays 3.
